// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data memory with fixed-latency, credit-limited load responses
// Optional: define DMEM_STORE_ACK_EN to queue an acknowledgement response for every accepted store.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_command,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_tag,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [2:0]  resp_tag,
  output logic        resp_misaligned,
  output logic        resp_is_store
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
`ifdef DMEM_STORE_ACK_EN
  localparam bit STORE_ACK = 1'b1;
`else
  localparam bit STORE_ACK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  tag;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic        misaligned;
    logic        is_store;
  } pipe_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  tag;
    logic        misaligned;
    logic        is_store;
  } resp_t;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          accept, is_load, is_store, misaligned, take_credit, pop;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data;
  logic [CW-1:0] credit_used, fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  pipe_t         in_e, push_e;
  logic          push_v;
  resp_t         fifo [OUTSTANDING];
  resp_t         head;
  logic          unused_addr;

  assign word_idx    = req_addr[AW+1:2];
  assign lane        = req_addr[1:0];
  assign unused_addr = ^req_addr[31:AW+2];
  assign is_load     = (req_command == BUS_LOAD);
  assign is_store    = (req_command == BUS_STORE);
  assign accept      = reset && req_ready && (req_command != BUS_NONE);
  assign take_credit = accept && (is_load || (STORE_ACK && is_store));

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_HALF:   misaligned = req_addr[0];
      SZ_WORD:   misaligned = (req_addr[1:0] != 2'b00);
      SZ_DOUBLE: misaligned = 1'b1;
      default:   misaligned = 1'b0;
    endcase
  end

  always_comb begin
    byte_en = 4'b0000;
    wr_data = req_data;
    case (req_size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{req_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_data[15:0]}};
      end
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    if (!(accept && is_store && !misaligned))
      byte_en = 4'b0000;
  end

  // Array contents survive reset; only lanes selected by byte_en change.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (byte_en[b])
        mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
  end

  always_comb begin
    in_e.word       = mem[word_idx];
    in_e.tag        = req_tag;
    in_e.size       = req_size;
    in_e.lane       = lane;
    in_e.misaligned = misaligned;
    in_e.is_store   = STORE_ACK && is_store;
  end

  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign push_v = take_credit;
      assign push_e = in_e;
    end else begin : g_pipe
      logic [LATENCY-2:0] stage_v;
      pipe_t              stage_e [LATENCY-1];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          stage_v <= '0;
        end else begin
          stage_v[0] <= take_credit;
          for (int i = 1; i < LATENCY - 1; i++)
            stage_v[i] <= stage_v[i-1];
        end
      end

      always_ff @(posedge clock) begin
        stage_e[0] <= in_e;
        for (int i = 1; i < LATENCY - 1; i++)
          stage_e[i] <= stage_e[i-1];
      end

      assign push_v = stage_v[LATENCY-2];
      assign push_e = stage_e[LATENCY-2];
    end
  endgenerate

  function automatic resp_t to_resp(input pipe_t e);
    logic [31:0] shifted;
    resp_t       r;
    shifted      = e.word >> {e.lane, 3'b000};
    r.tag        = e.tag;
    r.misaligned = e.misaligned;
    r.is_store   = e.is_store;
    r.data       = '0;
    if (!e.misaligned && !e.is_store) begin
      case (e.size)
        SZ_BYTE: r.data = {24'd0, shifted[7:0]};
        SZ_HALF: r.data = {16'd0, shifted[15:0]};
        default: r.data = shifted;
      endcase
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop = resp_valid && resp_ready;

  // Credit counts pipeline plus FIFO occupancy, so the FIFO can never overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      credit_used <= '0;
    end else begin
      if (push_v)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      fifo_count  <= fifo_count + CW'(push_v) - CW'(pop);
      credit_used <= credit_used + CW'(take_credit) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push_v)
      fifo[wr_ptr] <= to_resp(push_e);
  end

  assign head            = fifo[rd_ptr];
  assign req_ready       = (credit_used < CW'(OUTSTANDING));
  assign resp_valid      = (fifo_count != '0);
  assign resp_data       = resp_valid ? head.data : '0;
  assign resp_tag        = resp_valid ? head.tag : '0;
  assign resp_misaligned = resp_valid && head.misaligned;
  assign resp_is_store   = resp_valid && head.is_store;
endmodule
